alu_multicycle: RTL and testbench

Parametrised, sequential successor to the processor's combinational ALU. It adds a Start/Busy/Done handshake, registered results and flags, a Carry and Overflow flag, and iterative unsigned multiply and divide. It sits in the execute stage. The controller stalls the PC while `Busy` is high.

---
 rtl/alu_multicycle_pkg.sv | 31 +++
 rtl/alu_multicycle_iter_unit.sv | 73 +++++++
 rtl/alu_multicycle.sv | 200 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared types for the multicycle execute-stage ALU.
// Opcodes, FSM states and the registered flag bundle.
package definitions;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    XOR  = 4'd2,
    AND  = 4'd3,
    LSL  = 4'd4,
    LSR  = 4'd5,
    CMP  = 4'd6,
    MUL  = 4'd7,
    DIV  = 4'd8,
    PASS = 4'd9
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic divzero;
  } alu_flags_t;

endpackage

// File: rtl/alu_multicycle_iter_unit.sv
// Iterative MUL/DIV datapath: shift-add multiply, restoring divide.
// hi/lo registers act as accumulator/remainder and multiplier/quotient.
module alu_iter_unit
  import definitions::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         last_o,
  output logic         div_o,
  output logic [W-1:0] lo_n_o,
  output logic [W-1:0] hi_n_o
);

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  opnd_q;
  logic          div_q;

  logic [W:0]    mul_sum;
  logic [W:0]    trial;
  logic          fits;
  logic [W-1:0]  rem_n;

  always_comb begin
    mul_sum = {1'b0, hi_q};
    if (lo_q[0]) begin
      mul_sum = {1'b0, hi_q} + {1'b0, opnd_q};
    end
    trial = {hi_q, lo_q[W-1]};
    fits  = trial >= {1'b0, opnd_q};
    // True remainder is below the divisor, so the low W bits suffice.
    rem_n = fits ? (trial[W-1:0] - opnd_q) : trial[W-1:0];
    if (div_q) begin
      hi_n_o = rem_n;
      lo_n_o = {lo_q[W-2:0], fits};
    end else begin
      hi_n_o = mul_sum[W:1];
      lo_n_o = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= CW'(W);
      lo_q   <= div_i ? a_i : b_i;
      hi_q   <= '0;
      opnd_q <= div_i ? b_i : a_i;
      div_q  <= div_i;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - CW'(1);
      lo_q   <= lo_n_o;
      hi_q   <= hi_n_o;
    end
  end

  assign last_o = (cnt_q == CW'(1));
  assign div_o  = div_q;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with Start/Busy/Done handshake and registered results.
// Single-cycle ops complete next cycle; MUL/DIV iterate for W cycles.
module alu_multicycle
  import definitions::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [3:0]   OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Out,
  output logic [W-1:0] OutHi,
  output logic         Zero,
  output logic         Negative,
  output logic         Carry,
  output logic         Overflow,
  output logic         DivZero
);

  localparam logic [W-1:0] WV = W'(W);

  alu_op_t    op;
  alu_state_t state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] hi_q, hi_d;
  alu_flags_t flags_q, flags_d;
  logic       done_q, done_d;

  logic [W-1:0] sc_out;
  logic [W-1:0] sc_hi;
  alu_flags_t   sc_f;
  logic         sc_keep;
  logic         sc_nz;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic [W:0]   shl;
  logic [W:0]   shr;
  logic         big;

  logic         it_load;
  logic         it_div;
  logic         it_last;
  logic         it_mode;
  logic [W-1:0] it_lo;
  logic [W-1:0] it_hi;

  assign op = alu_op_t'(OP);

  alu_iter_unit #(
    .W (W),
    .CW(CW)
  ) u_iter (
    .clk_i (Clk),
    .rst_i (Reset),
    .load_i(it_load),
    .div_i (it_div),
    .a_i   (InputA),
    .b_i   (InputB),
    .last_o(it_last),
    .div_o (it_mode),
    .lo_n_o(it_lo),
    .hi_n_o(it_hi)
  );

  always_comb begin
    sc_out  = '0;
    sc_hi   = '0;
    sc_f    = '0;
    sc_keep = 1'b0;
    sc_nz   = 1'b0;
    sum     = {1'b0, InputA} + {1'b0, InputB};
    diff    = InputA - InputB;
    shl     = {1'b0, InputA} << InputB;
    shr     = {InputA, 1'b0} >> InputB;
    big     = InputB > WV;
    case (op)
      ADD: begin
        sc_out        = sum[W-1:0];
        sc_f.carry    = sum[W];
        sc_f.overflow = (InputA[W-1] == InputB[W-1])
                     && (sum[W-1] != InputA[W-1]);
        sc_nz         = 1'b1;
      end
      SUB, CMP: begin
        sc_out        = diff;
        sc_f.carry    = InputA >= InputB;
        sc_f.overflow = (InputA[W-1] != InputB[W-1])
                     && (diff[W-1] != InputA[W-1]);
        sc_keep       = (op == CMP);
        sc_nz         = 1'b1;
      end
      XOR: begin
        sc_out = InputA ^ InputB;
        sc_nz  = 1'b1;
      end
      AND: begin
        sc_out = InputA & InputB;
        sc_nz  = 1'b1;
      end
      PASS: begin
        sc_out = InputB;
        sc_nz  = 1'b1;
      end
      LSL: begin
        // Extra top bit captures the last bit shifted out.
        if (!big) {sc_f.carry, sc_out} = shl;
        sc_nz = 1'b1;
      end
      LSR: begin
        if (!big) {sc_out, sc_f.carry} = shr;
        sc_nz = 1'b1;
      end
      DIV: begin
        sc_out       = '1;
        sc_hi        = InputA;
        sc_f.divzero = 1'b1;
      end
      default: begin
        sc_out = '0;
      end
    endcase
    if (sc_nz) begin
      sc_f.zero     = (sc_out == '0);
      sc_f.negative = sc_out[W-1];
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    it_load = 1'b0;
    it_div  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (op == MUL || (op == DIV && InputB != '0)) begin
            it_load = 1'b1;
            it_div  = (op == DIV);
            state_d = EXEC;
          end else begin
            done_d  = 1'b1;
            flags_d = sc_f;
            if (!sc_keep) begin
              out_d = sc_out;
              hi_d  = sc_hi;
            end
          end
        end
      end
      EXEC: begin
        if (it_last) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          out_d        = it_lo;
          hi_d         = it_hi;
          flags_d      = '0;
          flags_d.zero = it_mode ? (it_lo == '0)
                                 : ({it_hi, it_lo} == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign Busy     = (state_q == EXEC);
  assign Done     = done_q;
  assign Out      = out_q;
  assign OutHi    = hi_q;
  assign Zero     = flags_q.zero;
  assign Negative = flags_q.negative;
  assign Carry    = flags_q.carry;
  assign Overflow = flags_q.overflow;
  assign DivZero  = flags_q.divzero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results,
// a negedge monitor pops and compares on every Done.
module tb_alu_multicycle;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [3:0]   OP;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Out;
  logic [W-1:0] OutHi;
  logic         Zero;
  logic         Negative;
  logic         Carry;
  logic         Overflow;
  logic         DivZero;

  alu_multicycle #(.W(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .OP      (OP),
    .InputA  (InputA),
    .InputB  (InputB),
    .Busy    (Busy),
    .Done    (Done),
    .Out     (Out),
    .OutHi   (OutHi),
    .Zero    (Zero),
    .Negative(Negative),
    .Carry   (Carry),
    .Overflow(Overflow),
    .DivZero (DivZero)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic z, n, c, v, dz;
    int   dcyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_hi  = '0;

  function automatic int sgn(int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic exp_t model(int op, int a, int b);
    exp_t e;
    int r, sr;
    longint p;
    bit nz;
    e.out = '0; e.hi = '0;
    e.z = 0; e.n = 0; e.c = 0; e.v = 0; e.dz = 0;
    e.dcyc = 0;
    nz = 0;
    case (op)
      0: begin
        r = a + b; e.out = W'(r & MASK); e.c = (r > MASK);
        sr = sgn(a) + sgn(b);
        e.v = (sr > MASK / 2) || (sr < -(MASK / 2) - 1); nz = 1;
      end
      1, 6: begin
        r = a - b; e.c = (a >= b);
        sr = sgn(a) - sgn(b);
        e.v = (sr > MASK / 2) || (sr < -(MASK / 2) - 1);
        if (op == 6) begin
          e.out = m_out; e.hi = m_hi;
          e.z = ((r & MASK) == 0);
          e.n = (((r & MASK) >> (W - 1)) & 1) == 1;
        end else begin
          e.out = W'(r & MASK); nz = 1;
        end
      end
      2: begin e.out = W'(a ^ b); nz = 1; end
      3: begin e.out = W'(a & b); nz = 1; end
      9: begin e.out = W'(b); nz = 1; end
      4: begin
        e.out = (b >= W) ? '0 : W'((a << b) & MASK);
        e.c = (b == 0 || b > W) ? 1'b0 : (((a >> (W - b)) & 1) == 1);
        nz = 1;
      end
      5: begin
        e.out = (b >= W) ? '0 : W'(a >> b);
        e.c = (b == 0 || b > W) ? 1'b0 : (((a >> (b - 1)) & 1) == 1);
        nz = 1;
      end
      7: begin
        p = longint'(a) * longint'(b);
        e.out = W'(p & MASK); e.hi = W'(p >> W); e.z = (p == 0);
      end
      8: begin
        if (b == 0) begin
          e.out = W'(MASK); e.hi = W'(a); e.dz = 1;
        end else begin
          e.out = W'(a / b); e.hi = W'(a % b); e.z = (a / b == 0);
        end
      end
      default: ;
    endcase
    if (nz) begin
      e.z = (e.out == 0);
      e.n = e.out[W-1];
    end
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(string name);
    chk(name, {Out, OutHi, Zero, Negative, Carry, Overflow, DivZero,
               Busy, Done}, 64'd0);
  endtask

  // Called just after an edge; the request is accepted at the next edge.
  task automatic issue(int op, int a, int b, bit pulse3);
    exp_t e;
    bit it;
    int acc;
    it = (op == 7) || (op == 8 && b != 0);
    OP = 4'(op); InputA = W'(a); InputB = W'(b); Start = 1'b1;
    acc = cyc + 1;
    e = model(op, a, b);
    e.dcyc = acc + (it ? W : 0);
    sbq.push_back(e);
    if (op != 6) begin
      m_out = e.out; m_hi = e.hi;
    end
    @(posedge Clk); #1;
    if (it) begin
      for (int i = 0; i < W; i++) begin
        chk("busy_exec", 64'(Busy), 64'd1);
        Start  = pulse3 ? (i == 2) : ($urandom_range(0, 2) == 0);
        OP     = 4'($urandom_range(0, 15));
        InputA = W'($urandom);
        InputB = W'($urandom);
        @(posedge Clk); #1;
      end
      Start = 1'b0;
      chk("busy_done", 64'(Busy), 64'd0);
    end else begin
      chk("busy_single", 64'(Busy), 64'd0);
    end
  endtask

  task automatic idle(int n);
    Start = 1'b0;
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: Done=1 with nothing pending, cycle %0d",
                 cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", {Out, OutHi, Zero, Negative, Carry, Overflow, DivZero},
            {mon_e.out, mon_e.hi, mon_e.z, mon_e.n, mon_e.c, mon_e.v,
             mon_e.dz});
        chk("done_cycle", 64'(cyc), 64'(mon_e.dcyc));
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].dcyc) begin
      mon_e = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_done: got none by cycle %0d, required at %0d",
               cyc, mon_e.dcyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int op, a, b;
    Reset = 1'b1; Start = 1'b1; OP = 4'd0;
    InputA = W'(1); InputB = W'(1);
    repeat (3) begin
      @(posedge Clk); #1;
    end
    chk_zero("reset_state");
    Reset = 1'b0; Start = 1'b0;
    idle(2);
    chk_zero("reset_wins_over_start");

    issue(0, 200, 100, 0);
    issue(1, 8'h80, 8'h01, 0);
    issue(6, 5, 5, 0);
    idle(1);
    issue(7, 13, 21, 1);
    issue(8, 200, 7, 0);
    issue(8, 200, 0, 0);
    issue(4, 8'h81, 1, 0);
    issue(5, 8'h81, 9, 0);
    issue(4, 8'h81, 8, 0);
    issue(5, 8'h81, 8, 0);
    issue(15, 3, 4, 0);
    idle(2);

    // Abort MUL 255*255 with Reset during its third EXEC cycle.
    OP = 4'd7; InputA = 8'hFF; InputB = 8'hFF; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk_zero("reset_abort");
    Reset = 1'b0;
    m_out = '0; m_hi = '0;
    issue(0, 1, 1, 0);
    idle(2);

    for (int k = 0; k < 400; k++) begin
      op = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15)
                                       : $urandom_range(0, 9);
      a = $urandom_range(0, MASK);
      case (op)
        4, 5:    b = $urandom_range(0, W + 3);
        8:       b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, MASK);
        default: b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, MASK);
      endcase
      issue(op, a, b, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(W + 3);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
